cacheline_arbiter: RTL
======================

Name: cacheline_arbiter

Overview:
- Shares the single cacheline adaptor (256-bit line ↔ 4×64-bit bursts) between the instruction cache (read-only) and the data cache (read/write).
- Arbitrates between the two caches and latches the winner's address, op and write line. Sequences one adaptor transaction at a time.
- Routes the adaptor's response and read line back to the granted cache only.
- Sits between the two L1 caches and the cacheline adaptor.

Parameters:
- FIXED_DPRIO, 0: 0 = round-robin between I and D; 1 = D always wins when both request.
- ADDR_W, 32: address width.
- LINE_W, 256: cacheline width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_address  in  ADDR_W  I-cache line address.
- i_read  in  1  I-cache read request; level, held until i_resp.
- i_rdata  out  LINE_W  line returned to I-cache.
- i_resp  out  1  I-cache completion, one-cycle pulse.
- d_address  in  ADDR_W  D-cache line address.
- d_read  in  1  D-cache read request; level.
- d_write  in  1  D-cache write-back request; level.
- d_wdata  in  LINE_W  D-cache write line.
- d_rdata  out  LINE_W  line returned to D-cache.
- d_resp  out  1  D-cache completion, one-cycle pulse.
- a_address  out  ADDR_W  to adaptor address_i.
- a_read  out  1  to adaptor read_i.
- a_write  out  1  to adaptor write_i.
- a_wdata  out  LINE_W  to adaptor line_i.
- a_rdata  in  LINE_W  from adaptor line_o.
- a_resp  in  1  from adaptor resp_o.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; addr_q=0, wdata_q=0, op_q=NONE, last_grant=D (so I wins the first tie).
  - All outputs 0 while reset is asserted.
- Reset mid-transaction: abort immediately, no resp to either cache. The adaptor must be reset concurrently; the system reset spans both.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE:
  - Requests: req_i = i_read; req_d = d_read | d_write.
  - Neither → stay in IDLE.
  - One → grant it.
  - Both → FIXED_DPRIO=1: D wins; FIXED_DPRIO=0: the requester not equal to last_grant wins.
  - On grant, at the same edge: latch addr_q, op_q (WRITE if d_write, else READ; I is always READ), wdata_q (d_wdata for D, else 0); update last_grant; go to SERVE_I or SERVE_D.
  - d_read & d_write together: treated as WRITE.
- SERVE_x:
  - a_address=addr_q; a_read = (op_q==READ); a_write = (op_q==WRITE); a_wdata=wdata_q.
  - Request inputs may change without effect (latched).
  - a_resp=1: x_resp=1 in that same cycle (combinational); next state RELEASE.
  - a_resp=0: hold.
- RELEASE:
  - a_read=a_write=0 for exactly one cycle; a_resp ignored.
  - Unconditionally → IDLE.
  - Guarantees the adaptor sees its request drop and the requester has dropped its request before re-arbitration.
- Minimum turnaround: request seen in IDLE at cycle 0 → a_read/a_write=1 from cycle 1. Response at cycle N → next grant issued at N+2 at earliest.
- Read data: i_rdata and d_rdata both continuously equal a_rdata. Only the resp strobes are gated by grant.
- a_resp in IDLE or RELEASE: ignored; no strobe to either cache.
- i_resp and d_resp are never both 1 in the same cycle.
- Caches must deassert their request in the cycle after their resp. A request still held in IDLE is re-granted as a new transaction.

Test Plan:
- Reset: reset=0 mid-SERVE_D → all outputs 0 immediately; after release, i_read=1 with addr 0x0000_1000 → a_read=1 and a_address=0x0000_1000 one cycle later.
- Single I read: i_read=1, addr 0x40; adaptor returns line 0xDEAD…BEEF with a_resp after 6 cycles → i_resp=1 for one cycle, i_rdata=0xDEAD…BEEF, d_resp stays 0, a_read=0 in the following (RELEASE) cycle.
- D write-back: d_write=1, addr 0x80, d_wdata=256'hA5…A5; change d_wdata mid-transaction → a_write=1, a_wdata stays A5…A5, a_read=0 throughout, d_resp on a_resp.
- Tie, FIXED_DPRIO=0: i_read and d_read held continuously → grants alternate I, D, I, D; each new grant begins exactly 2 cycles after the previous a_resp.
- Tie, FIXED_DPRIO=1: both requesting → D granted first; I granted only once d_read drops.
- Stray response: a_resp=1 pulsed while in IDLE, with no request pending → i_resp=d_resp=0, state remains IDLE.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// -----------------------------------------------------------------------------
// cacheline_arbiter
//
// Shares one cacheline adaptor between the instruction cache (read-only) and
// the data cache (read / write-back). One adaptor transaction runs at a time.
// The winner's address, operation and write line are latched at grant, so the
// caches may change their request inputs while the transaction is in flight.
// After every completion the arbiter spends one RELEASE cycle with the adaptor
// request low before it arbitrates again.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   i_address/i_read    I-cache request (level)
//   i_rdata/i_resp      line back to the I-cache, one-cycle completion strobe
//   d_address/d_read/   D-cache request (level); read+write together is a write
//   d_write/d_wdata
//   d_rdata/d_resp      line back to the D-cache, one-cycle completion strobe
//   a_address/a_read/   request to the cacheline adaptor
//   a_write/a_wdata
//   a_rdata/a_resp      adaptor read line and completion
//
// Parameters:
//   FIXED_DPRIO  0: round-robin on a tie, 1: the D-cache always wins a tie
//   ADDR_W       address width
//   LINE_W       cacheline width
// -----------------------------------------------------------------------------
module cacheline_arbiter #(
    parameter bit FIXED_DPRIO = 1'b0,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] a_address,
    output logic              a_read,
    output logic              a_write,
    output logic [LINE_W-1:0] a_wdata,
    input  logic [LINE_W-1:0] a_rdata,
    input  logic              a_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    // 1 = the last grant went to the D-cache
    logic              last_grant_d_q, last_grant_d_d;

    logic              req_i_s;
    logic              req_d_s;
    logic              grant_d_s;

    // Arbitration: decide which cache would win if we granted this cycle.
    always_comb begin
        req_i_s   = i_read;
        req_d_s   = d_read | d_write;
        grant_d_s = 1'b0;
        if (req_i_s && req_d_s) begin
            // On a tie, round-robin favours whoever did not win last time.
            grant_d_s = FIXED_DPRIO ? 1'b1 : ~last_grant_d_q;
        end else begin
            grant_d_s = req_d_s;
        end
    end

    // Next-state, latch control and adaptor/cache outputs.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        last_grant_d_d = last_grant_d_q;
        a_address      = {ADDR_W{1'b0}};
        a_wdata        = {LINE_W{1'b0}};
        a_read         = 1'b0;
        a_write        = 1'b0;
        i_resp         = 1'b0;
        d_resp         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i_s || req_d_s) begin
                    last_grant_d_d = grant_d_s;
                    if (grant_d_s) begin
                        state_d = SERVE_D;
                        addr_d  = d_address;
                        op_d    = d_write ? OP_WRITE : OP_READ;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = i_address;
                        op_d    = OP_READ;
                        wdata_d = {LINE_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                a_address = addr_q;
                a_wdata   = wdata_q;
                a_read    = (op_q == OP_READ);
                a_write   = (op_q == OP_WRITE);
                if (a_resp) begin
                    // Completion strobe is combinational with the adaptor's.
                    i_resp  = (state_q == SERVE_I);
                    d_resp  = (state_q == SERVE_D);
                    state_d = RELEASE;
                end else begin
                    state_d = state_q;
                end
            end
            RELEASE: begin
                // One quiet cycle so the adaptor sees its request drop.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            op_q           <= OP_NONE;
            addr_q         <= {ADDR_W{1'b0}};
            wdata_q        <= {LINE_W{1'b0}};
            last_grant_d_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            last_grant_d_q <= last_grant_d_d;
        end
    end

    // Read line fans out to both caches; forced to zero while in reset.
    assign i_rdata = reset ? a_rdata : {LINE_W{1'b0}};
    assign d_rdata = reset ? a_rdata : {LINE_W{1'b0}};

endmodule
